// File: rtl/vga_gl_pkg.sv
// Shared definitions for the VGA-GL framebuffer scheduler: default 640x480@60 timing
// and the memory-arbiter state encoding.
package vga_gl_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int V_TOTAL = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    DRAW = 2'd2
  } sched_state_t;

endpackage

// File: rtl/vga_fb_scheduler_if.sv
// Single-transaction memory bus: req held until a one-cycle ack, rdata valid with ack.
interface vga_fb_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vga_timing.sv
// Raster counters with registered sync/de outputs aligned to x/y, plus the
// end-of-active-line prefetch trigger for the next displayed line.
module vga_timing
  import vga_gl_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       de,
  output logic       fetch_trig,
  output logic [9:0] fetch_line
);

  localparam logic [9:0] X_LAST = 10'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [9:0] Y_LAST = 10'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  always_comb begin
    x_nxt = x + 10'd1;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? '0 : y + 10'd1;
    end
  end

  // Sync and de are decoded from the next position so they line up with x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      de      <= 1'b0;
    end else begin
      x       <= x_nxt;
      y       <= y_nxt;
      hsync_n <= !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
      vsync_n <= !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
      de      <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    end
  end

  assign fetch_line = (y == Y_LAST) ? '0 : y + 10'd1;
  assign fetch_trig = (x == X_ACT) && (fetch_line < Y_ACT);

endmodule

// File: rtl/vga_fb_scheduler.sv
// Raster sequencer plus single-port framebuffer arbiter: line prefetch into the
// double-banked line buffer has priority over draw-engine traffic.
module vga_fb_scheduler
  import vga_gl_pkg::*;
#(
  parameter int H_ACTIVE       = VGA_H_ACTIVE,
  parameter int H_FP           = VGA_H_FP,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BP           = VGA_H_BP,
  parameter int V_ACTIVE       = VGA_V_ACTIVE,
  parameter int V_FP           = VGA_V_FP,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BP           = VGA_V_BP,
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 16,
  parameter int WORDS_PER_LINE = H_ACTIVE / DATA_W,
  parameter int FB_BASE        = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                hsync_n,
  output logic                vsync_n,
  output logic                de,
  output logic [9:0]          x,
  output logic [9:0]          y,
  output logic                lb_we,
  output logic                lb_bank,
  output logic [6:0]          lb_waddr,
  output logic [DATA_W-1:0]   lb_wdata,
  vga_fb_scheduler_if.master  mem,
  vga_fb_scheduler_if.slave   draw,
  output logic                underrun
);

  logic         fetch_trig;
  logic [9:0]   fetch_line;

  sched_state_t state;
  logic         pend;
  logic         stale;
  logic [6:0]   idx;
  logic [9:0]   line;
  logic         mem_req_r;
  logic         mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic         gnt_r;
  logic [DATA_W-1:0] draw_rdata_r;

  logic issue_disp;
  logic issue_draw;
  logic disp_ack;
  logic draw_ack;
  logic last_word;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [9:0] ln, input logic [6:0] wi);
    return ADDR_W'(FB_BASE) + ADDR_W'(ln) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(wi);
  endfunction

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .de         (de),
    .fetch_trig (fetch_trig),
    .fetch_line (fetch_line)
  );

  // The cycle draw_gnt is high the engine still holds draw_req; it must not re-issue.
  always_comb begin
    issue_disp = 1'b0;
    issue_draw = 1'b0;
    disp_ack   = 1'b0;
    draw_ack   = 1'b0;
    if (state == IDLE) begin
      issue_disp = pend;
      issue_draw = !pend && draw.req && !gnt_r;
    end
    if (state == DISP) disp_ack = mem.ack;
    if (state == DRAW) draw_ack = mem.ack;
    last_word = (idx == 7'(WORDS_PER_LINE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      stale     <= 1'b0;
      idx       <= '0;
      line      <= '0;
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      lb_we     <= 1'b0;
      gnt_r     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      lb_we <= 1'b0;
      gnt_r <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_disp) begin
            mem_req_r <= 1'b1;
            mem_we_r  <= 1'b0;
            state     <= DISP;
          end else if (issue_draw) begin
            mem_req_r <= 1'b1;
            mem_we_r  <= draw.we;
            state     <= DRAW;
          end
        end
        DISP: begin
          if (mem.ack) begin
            mem_req_r <= 1'b0;
            stale     <= 1'b0;
            state     <= IDLE;
            if (!stale) begin
              lb_we <= 1'b1;
              idx   <= last_word ? '0 : idx + 7'd1;
              if (last_word) pend <= 1'b0;
            end
          end
        end
        DRAW: begin
          if (mem.ack) begin
            mem_req_r <= 1'b0;
            gnt_r     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (pend && (x == 10'd0) && (y == line)) underrun <= 1'b1;

      // A restart orphans any read already issued for the abandoned line.
      if (fetch_trig) begin
        if (pend) underrun <= 1'b1;
        pend  <= 1'b1;
        idx   <= '0;
        line  <= fetch_line;
        stale <= ((state == DISP) && !mem.ack) || issue_disp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_disp) begin
      mem_addr_r <= word_addr(line, idx);
    end else if (issue_draw) begin
      mem_addr_r  <= draw.addr;
      mem_wdata_r <= draw.wdata;
    end
    if (disp_ack) begin
      lb_waddr <= idx;
      lb_wdata <= mem.rdata;
      lb_bank  <= line[0];
    end
    if (draw_ack) draw_rdata_r <= mem.rdata;
  end

  assign mem.req    = mem_req_r;
  assign mem.we     = mem_we_r;
  assign mem.addr   = mem_addr_r;
  assign mem.wdata  = mem_wdata_r;
  assign draw.ack   = gnt_r;
  assign draw.rdata = draw_rdata_r;

endmodule
